// File: rtl/lvds_align_pkg.sv
// Shared definitions for the LVDS receive word aligner: lane FSM states,
// default geometry and the counter-width helper.
package lvds_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED,
        ST_FAIL
    } lane_state_e;

    localparam int DEF_SER_FACTOR  = 6;
    localparam int DEF_MATCH_COUNT = 16;
    localparam int DEF_SLIP_WAIT   = 4;

    // Bits needed for a counter that must hold the value max_val itself.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lvds_rx_align_ch.sv
// One lane of the word aligner: hunts for the training word by pulsing the
// SERDES bitslip, then reports lock or failure for that lane.
module lvds_rx_align_ch
    import lvds_align_pkg::*;
#(
    parameter int                    SER_FACTOR    = DEF_SER_FACTOR,
    parameter logic [SER_FACTOR-1:0] TRAIN_PATTERN = 6'b111000,
    parameter int                    MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int                    SLIP_WAIT     = DEF_SLIP_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lock,
    input  logic                  start,
    input  logic [SER_FACTOR-1:0] word,
    output logic                  bitslip,
    output logic                  aligned,
    output logic                  fail,
    output logic                  busy
);

    localparam int MW = cnt_w(MATCH_COUNT);
    localparam int SW = cnt_w(SER_FACTOR);
    localparam int WW = cnt_w(SLIP_WAIT);

    lane_state_e   state;
    logic [MW-1:0] match_cnt;
    logic [SW-1:0] slip_cnt;
    logic [WW-1:0] wait_cnt;

    assign busy = (state == ST_SETTLE) || (state == ST_CHECK) ||
                  (state == ST_SLIP)   || (state == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            slip_cnt  <= '0;
            wait_cnt  <= '0;
            bitslip   <= 1'b0;
            aligned   <= 1'b0;
            fail      <= 1'b0;
        end else if (!lock) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            slip_cnt  <= '0;
            wait_cnt  <= '0;
            bitslip   <= 1'b0;
            aligned   <= 1'b0;
            fail      <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                ST_IDLE, ST_LOCKED, ST_FAIL: begin
                    if (start) begin
                        state     <= ST_SETTLE;
                        match_cnt <= '0;
                        slip_cnt  <= '0;
                        wait_cnt  <= '0;
                        aligned   <= 1'b0;
                        fail      <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (wait_cnt == WW'(SLIP_WAIT - 1)) state <= ST_CHECK;
                    else wait_cnt <= wait_cnt + 1'b1;
                end
                ST_CHECK: begin
                    if (word == TRAIN_PATTERN) begin
                        match_cnt <= match_cnt + 1'b1;
                        if (match_cnt == MW'(MATCH_COUNT - 1)) begin
                            state   <= ST_LOCKED;
                            aligned <= 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                        // Every phase has been tried once; the lane is dead.
                        if (slip_cnt == SW'(SER_FACTOR)) begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state   <= ST_SLIP;
                            bitslip <= 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    slip_cnt <= slip_cnt + 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    match_cnt <= '0;
                    if (wait_cnt == WW'(SLIP_WAIT - 1)) state <= ST_CHECK;
                    else wait_cnt <= wait_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lvds_rx_word_aligner.sv
// N-lane LVDS word aligner: PLL-lock synchroniser, start qualification,
// per-lane aligners and the aligned-data output register.
module lvds_rx_word_aligner
    import lvds_align_pkg::*;
#(
    parameter int                    NUM_CH        = 4,
    parameter int                    SER_FACTOR    = DEF_SER_FACTOR,
    parameter logic [SER_FACTOR-1:0] TRAIN_PATTERN = 6'b111000,
    parameter int                    MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int                    SLIP_WAIT     = DEF_SLIP_WAIT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pll_locked,
    input  logic                         align_start,
    input  logic [NUM_CH*SER_FACTOR-1:0] rx_data,
    output logic [NUM_CH-1:0]            bitslip,
    output logic [NUM_CH-1:0]            ch_aligned,
    output logic [NUM_CH-1:0]            align_fail,
    output logic                         align_done,
    output logic [NUM_CH*SER_FACTOR-1:0] rx_data_out,
    output logic                         rx_valid
);

    logic [1:0]        lock_sync;
    logic              lock_s;
    logic [NUM_CH-1:0] busy;
    logic              start_ok;
    logic              all_settled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_sync <= 2'b00;
        else        lock_sync <= {lock_sync[0], pll_locked};
    end

    assign lock_s      = lock_sync[1];
    // A restart mid-search would desynchronise lanes, so only idle or finished lanes accept it.
    assign start_ok    = align_start & lock_s & ~(|busy);
    assign all_settled = &(ch_aligned | align_fail);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        lvds_rx_align_ch #(
            .SER_FACTOR   (SER_FACTOR),
            .TRAIN_PATTERN(TRAIN_PATTERN),
            .MATCH_COUNT  (MATCH_COUNT),
            .SLIP_WAIT    (SLIP_WAIT)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .lock   (lock_s),
            .start  (start_ok),
            .word   (rx_data[i*SER_FACTOR +: SER_FACTOR]),
            .bitslip(bitslip[i]),
            .aligned(ch_aligned[i]),
            .fail   (align_fail[i]),
            .busy   (busy[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_done  <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data_out <= '0;
        end else begin
            align_done  <= lock_s & all_settled;
            rx_valid    <= lock_s & all_settled & ~(|align_fail);
            rx_data_out <= rx_data;
        end
    end

endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
// Directed bench for lvds_rx_word_aligner with a SERDES model that rotates
// each lane word by one bit per bitslip pulse.
module tb_lvds_rx_word_aligner;

    localparam logic [5:0] TRAIN = 6'b111000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pll_locked;
    logic        align_start;
    logic [23:0] rx_data;
    logic [3:0]  bitslip;
    logic [3:0]  ch_aligned;
    logic [3:0]  align_fail;
    logic        align_done;
    logic [23:0] rx_data_out;
    logic        rx_valid;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int need[4]  = '{0, 1, 2, 5};
    int off[4]   = '{default: 0};
    int slips[4] = '{default: 0};
    int base[4]  = '{default: 0};
    bit dead3      = 1'b0;
    bit corrupt_en = 1'b0;
    bit corrupt0   = 1'b0;
    bit last_done  = 1'b0;
    bit last_valid = 1'b0;
    logic [5:0]  lane_w;
    logic [23:0] saved;

    always #5 clk = ~clk;

    lvds_rx_word_aligner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .align_start(align_start),
        .rx_data    (rx_data),
        .bitslip    (bitslip),
        .ch_aligned (ch_aligned),
        .align_fail (align_fail),
        .align_done (align_done),
        .rx_data_out(rx_data_out),
        .rx_valid   (rx_valid)
    );

    function automatic logic [5:0] rotl(input logic [5:0] w, input int n);
        logic [11:0] d;
        d = {w, w} << n;
        return d[11:6];
    endfunction

    always_comb begin
        rx_data = '0;
        lane_w  = '0;
        for (int i = 0; i < 4; i++) begin
            lane_w = rotl(TRAIN, (off[i] + slips[i]) % 6);
            if (i == 3 && dead3)    lane_w = 6'b000000;
            if (i == 0 && corrupt0) lane_w = 6'b010101;
            rx_data[i*6 +: 6] = lane_w;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bitslip[i] === 1'b1) slips[i] <= slips[i] + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Misalign each lane so that exactly need[i] slips bring it back to TRAIN.
    task automatic prep();
        for (int i = 0; i < 4; i++) begin
            off[i]  = (12 - need[i] - (slips[i] % 6)) % 6;
            base[i] = slips[i];
        end
    endtask

    task automatic run_align(input int last);
        int         lock_t[4];
        int         fail_t[4];
        int         sl_start[4];
        int         sl_num[4];
        int         done_t;
        bit         any_fail;
        logic [3:0] e_al, e_fl, e_bs;
        logic       e_done, e_valid;
        prep();
        done_t   = 0;
        any_fail = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sl_start[i] = 6;
            sl_num[i]   = need[i];
            lock_t[i]   = 21 + 6 * need[i];
            fail_t[i]   = -1;
            if (i == 3 && dead3) begin
                sl_num[i] = 6;
                lock_t[i] = -1;
                fail_t[i] = 42;
            end
            if (i == 0 && corrupt_en) begin
                sl_start[i] = 16;
                sl_num[i]   = 6;
                lock_t[i]   = 67;
            end
            if (lock_t[i] >= 0 && lock_t[i] + 1 > done_t) done_t = lock_t[i] + 1;
            if (fail_t[i] >= 0 && fail_t[i] + 1 > done_t) done_t = fail_t[i] + 1;
            if (fail_t[i] >= 0) any_fail = 1'b1;
        end
        align_start = 1'b1;
        cyc = 0;
        step();
        align_start = 1'b0;
        while (cyc <= last) begin
            for (int i = 0; i < 4; i++) begin
                e_al[i] = (lock_t[i] >= 0) && (cyc >= lock_t[i]);
                e_fl[i] = (fail_t[i] >= 0) && (cyc >= fail_t[i]);
                e_bs[i] = (cyc >= sl_start[i]) && ((cyc - sl_start[i]) % 6 == 0) &&
                          ((cyc - sl_start[i]) / 6 < sl_num[i]);
            end
            e_done  = (cyc >= done_t) || (cyc == 1 && last_done);
            e_valid = ((cyc >= done_t) && !any_fail) || (cyc == 1 && last_valid);
            chk("ch_aligned", {28'd0, ch_aligned}, {28'd0, e_al});
            chk("align_fail", {28'd0, align_fail}, {28'd0, e_fl});
            chk("bitslip",    {28'd0, bitslip},    {28'd0, e_bs});
            chk("align_done", {31'd0, align_done}, {31'd0, e_done});
            chk("rx_valid",   {31'd0, rx_valid},   {31'd0, e_valid});
            if (cyc == 2) saved = rx_data;
            if (cyc == 3) chk("rx_data_out", {8'd0, rx_data_out}, {8'd0, saved});
            if (cyc == 10) align_start = 1'b1;
            if (corrupt_en && cyc == 15) corrupt0 = 1'b1;
            step();
            align_start = 1'b0;
            corrupt0    = 1'b0;
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("slip_count%0d", i), slips[i] - base[i], sl_num[i]);
        last_done  = 1'b1;
        last_valid = !any_fail;
    endtask

    initial begin
        rst_n       = 1'b0;
        pll_locked  = 1'b1;
        align_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bitslip",  {28'd0, bitslip},    32'd0);
        chk("reset_aligned",  {28'd0, ch_aligned}, 32'd0);
        chk("reset_fail",     {28'd0, align_fail}, 32'd0);
        chk("reset_done",     {31'd0, align_done}, 32'd0);
        chk("reset_valid",    {31'd0, rx_valid},   32'd0);
        chk("reset_data_out", {8'd0, rx_data_out}, 32'd0);
        rst_n = 1'b1;
        repeat (4) step();

        // Lanes needing 0,1,2,5 slips, with a stray start at cycle 10.
        need = '{0, 1, 2, 5};
        run_align(56);

        // Restart after done repeats the same timing.
        run_align(56);

        // Lane 3 dead.
        need  = '{0, 1, 2, 0};
        dead3 = 1'b1;
        run_align(50);
        dead3 = 1'b0;

        // Lane 0 corrupted once after 10 matches.
        need       = '{0, 0, 0, 0};
        corrupt_en = 1'b1;
        run_align(70);
        corrupt_en = 1'b0;

        // PLL lock lost while lane 2 is waiting after its second slip.
        need = '{0, 1, 2, 5};
        prep();
        align_start = 1'b1;
        cyc = 0;
        step();
        align_start = 1'b0;
        while (cyc < 14) begin
            if (cyc == 12) chk("bitslip_pre_drop", {28'd0, bitslip}, 32'hC);
            step();
        end
        pll_locked = 1'b0;
        repeat (3) step();
        chk("drop_bitslip", {28'd0, bitslip},    32'd0);
        chk("drop_aligned", {28'd0, ch_aligned}, 32'd0);
        chk("drop_fail",    {28'd0, align_fail}, 32'd0);
        chk("drop_done",    {31'd0, align_done}, 32'd0);
        chk("drop_valid",   {31'd0, rx_valid},   32'd0);
        while (cyc < 30) begin
            step();
            chk("unlocked_aligned", {28'd0, ch_aligned}, 32'd0);
            chk("unlocked_bitslip", {28'd0, bitslip},    32'd0);
        end
        pll_locked = 1'b1;
        repeat (10) step();
        chk("relock_aligned", {28'd0, ch_aligned}, 32'd0);
        chk("relock_done",    {31'd0, align_done}, 32'd0);
        chk("relock_bitslip", {28'd0, bitslip},    32'd0);
        last_done  = 1'b0;
        last_valid = 1'b0;
        run_align(56);

        // Asynchronous reset while lanes 2 and 3 are checking.
        prep();
        align_start = 1'b1;
        cyc = 0;
        step();
        align_start = 1'b0;
        while (cyc < 23) step();
        chk("pre_reset_aligned", {28'd0, ch_aligned}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_bitslip",  {28'd0, bitslip},    32'd0);
        chk("areset_aligned",  {28'd0, ch_aligned}, 32'd0);
        chk("areset_fail",     {28'd0, align_fail}, 32'd0);
        chk("areset_done",     {31'd0, align_done}, 32'd0);
        chk("areset_valid",    {31'd0, rx_valid},   32'd0);
        chk("areset_data_out", {8'd0, rx_data_out}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
